// File: rtl/id_ex_stage_reg_if.sv
// ID->EX pipeline bundle: decoded fields from ID (master side) and their
// registered copies presented to EX (slave side drives them).
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
);
  logic              id_valid;
  logic [OP_W-1:0]   id_aluop;
  logic [SEL_W-1:0]  id_alusel;
  logic [DATA_W-1:0] id_reg1;
  logic [DATA_W-1:0] id_reg2;
  logic [ADDR_W-1:0] id_wd;
  logic              id_wreg;
  logic [DATA_W-1:0] id_inst;
  logic [DATA_W-1:0] id_pc;
  logic              id_in_delayslot;
  logic              id_next_in_delayslot;

  logic              ex_valid;
  logic [OP_W-1:0]   ex_aluop;
  logic [SEL_W-1:0]  ex_alusel;
  logic [DATA_W-1:0] ex_reg1;
  logic [DATA_W-1:0] ex_reg2;
  logic [ADDR_W-1:0] ex_wd;
  logic              ex_wreg;
  logic [DATA_W-1:0] ex_inst;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_in_delayslot;

  modport master (
    output id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
           id_inst, id_pc, id_in_delayslot, id_next_in_delayslot,
    input  ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
           ex_inst, ex_pc, ex_in_delayslot
  );

  modport slave (
    input  id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
           id_inst, id_pc, id_in_delayslot, id_next_in_delayslot,
    output ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
           ex_inst, ex_pc, ex_in_delayslot
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with flush, per-instruction valid, delay-slot
// tracking fed back to ID and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
  parameter int NSTAGE    = 6,
  parameter int STAGE_IDX = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int OP_W      = 8,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall,
  input  logic              flush,
  id_ex_stage_reg_if.slave  bus,
  output logic              is_in_delayslot,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   aluop;
    logic [SEL_W-1:0]  alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] pc;
    logic              in_delayslot;
  } ex_t;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } action_e;

  action_e          action;
  ex_t              id_pkt;
  ex_t              ex_q, ex_d;
  logic             ds_q, ds_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A bubble is ID stalled while EX keeps running; only those two stall bits matter.
  always_comb begin
    action = ACT_HOLD;
    if (rst)
      action = ACT_RESET;
    else if (flush)
      action = ACT_FLUSH;
    else if (stall[STAGE_IDX] && !stall[STAGE_IDX+1])
      action = ACT_BUBBLE;
    else if (!stall[STAGE_IDX])
      action = ACT_ADVANCE;
  end

  always_comb begin
    id_pkt              = '0;
    id_pkt.valid        = 1'b1;
    id_pkt.aluop        = bus.id_aluop;
    id_pkt.alusel       = bus.id_alusel;
    id_pkt.reg1         = bus.id_reg1;
    id_pkt.reg2         = bus.id_reg2;
    id_pkt.wd           = bus.id_wd;
    id_pkt.wreg         = bus.id_wreg;
    id_pkt.inst         = bus.id_inst;
    id_pkt.pc           = bus.id_pc;
    id_pkt.in_delayslot = bus.id_in_delayslot;
  end

  // An invalid ID slot advances as an all-zero NOP so ex_wreg can never leak.
  always_comb begin
    ex_d  = ex_q;
    ds_d  = ds_q;
    cnt_d = cnt_q;
    unique case (action)
      ACT_RESET: begin
        ex_d  = '0;
        ds_d  = 1'b0;
        cnt_d = '0;
      end
      ACT_FLUSH: begin
        ex_d = '0;
        ds_d = 1'b0;
      end
      ACT_BUBBLE: begin
        ex_d = '0;
        if (cnt_q != {CNT_W{1'b1}})
          cnt_d = cnt_q + CNT_W'(1);
      end
      ACT_ADVANCE: begin
        ex_d = bus.id_valid ? id_pkt : '0;
        ds_d = bus.id_next_in_delayslot;
      end
      ACT_HOLD: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    ex_q  <= ex_d;
    ds_q  <= ds_d;
    cnt_q <= cnt_d;
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_aluop        = ex_q.aluop;
  assign bus.ex_alusel       = ex_q.alusel;
  assign bus.ex_reg1         = ex_q.reg1;
  assign bus.ex_reg2         = ex_q.reg2;
  assign bus.ex_wd           = ex_q.wd;
  assign bus.ex_wreg         = ex_q.wreg;
  assign bus.ex_inst         = ex_q.inst;
  assign bus.ex_pc           = ex_q.pc;
  assign bus.ex_in_delayslot = ex_q.in_delayslot;
  assign is_in_delayslot     = ds_q;
  assign bubble_cnt          = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: default instance plus a CNT_W=2 instance
// used to exercise bubble-counter saturation.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic [5:0]  stall_sat;
  logic        is_ds;
  logic        is_ds_sat;
  logic [15:0] cnt;
  logic [1:0]  cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage_reg_if #(.DATA_W(32), .ADDR_W(5), .OP_W(8), .SEL_W(3)) bus ();
  id_ex_stage_reg_if #(.DATA_W(32), .ADDR_W(5), .OP_W(8), .SEL_W(3)) bus_sat ();

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus),
    .is_in_delayslot(is_ds), .bubble_cnt(cnt)
  );

  id_ex_stage_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall_sat), .flush(flush), .bus(bus_sat),
    .is_in_delayslot(is_ds_sat), .bubble_cnt(cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic v, input logic [7:0] op, input logic [2:0] sel,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] wd, input logic wr,
                                input logic [31:0] inst, input logic [31:0] pc,
                                input logic in_ds, input logic next_ds);
    bus.id_valid             = v;
    bus.id_aluop             = op;
    bus.id_alusel            = sel;
    bus.id_reg1              = r1;
    bus.id_reg2              = r2;
    bus.id_wd                = wd;
    bus.id_wreg              = wr;
    bus.id_inst              = inst;
    bus.id_pc                = pc;
    bus.id_in_delayslot      = in_ds;
    bus.id_next_in_delayslot = next_ds;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ex(input string t, input logic v, input logic [7:0] op,
                          input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] wd, input logic wr, input logic [31:0] inst,
                          input logic [31:0] pc, input logic ids);
    check_output({t, ".valid"},  32'(bus.ex_valid),        32'(v));
    check_output({t, ".aluop"},  32'(bus.ex_aluop),        32'(op));
    check_output({t, ".alusel"}, 32'(bus.ex_alusel),       32'(sel));
    check_output({t, ".reg1"},   bus.ex_reg1,              r1);
    check_output({t, ".reg2"},   bus.ex_reg2,              r2);
    check_output({t, ".wd"},     32'(bus.ex_wd),           32'(wd));
    check_output({t, ".wreg"},   32'(bus.ex_wreg),         32'(wr));
    check_output({t, ".inst"},   bus.ex_inst,              inst);
    check_output({t, ".pc"},     bus.ex_pc,                pc);
    check_output({t, ".in_ds"},  32'(bus.ex_in_delayslot), 32'(ids));
  endtask

  initial begin
    bus_sat.id_valid             = 1'b0;
    bus_sat.id_aluop             = '0;
    bus_sat.id_alusel            = '0;
    bus_sat.id_reg1              = '0;
    bus_sat.id_reg2              = '0;
    bus_sat.id_wd                = '0;
    bus_sat.id_wreg              = 1'b0;
    bus_sat.id_inst              = '0;
    bus_sat.id_pc                = '0;
    bus_sat.id_in_delayslot      = 1'b0;
    bus_sat.id_next_in_delayslot = 1'b0;

    // Reset with live ID inputs: everything must come up zero
    rst = 1'b1; flush = 1'b0; stall = '0; stall_sat = '0;
    apply_stimulus(1'b1, 8'h21, 3'd1, 32'd5, 32'd7, 5'd3, 1'b1, 32'h00A63821, 32'h100, 1'b1, 1'b1);
    step();
    check_ex("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rst.is_ds", 32'(is_ds), 32'd0);
    check_output("rst.cnt", 32'(cnt), 32'd0);
    check_output("rst.cnt_sat", 32'(cnt_sat), 32'd0);

    // First advance
    rst = 1'b0;
    apply_stimulus(1'b1, 8'h21, 3'd1, 32'd5, 32'd7, 5'd3, 1'b1, 32'h00A63821, 32'h100, 1'b0, 1'b0);
    step();
    check_ex("adv", 1, 8'h21, 3'd1, 32'd5, 32'd7, 5'd3, 1, 32'h00A63821, 32'h100, 0);

    // Three bubbles
    stall = 6'b000111;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_output($sformatf("bub%0d.valid", i), 32'(bus.ex_valid), 32'd0);
      check_output($sformatf("bub%0d.wreg", i), 32'(bus.ex_wreg), 32'd0);
      check_output($sformatf("bub%0d.aluop", i), 32'(bus.ex_aluop), 32'd0);
      check_output($sformatf("bub%0d.pc", i), bus.ex_pc, 32'd0);
      check_output($sformatf("bub%0d.cnt", i), 32'(cnt), 32'(i));
    end

    // Hold does not count
    stall = 6'b001111;
    step();
    check_output("hold0.cnt", 32'(cnt), 32'd3);
    check_output("hold0.valid", 32'(bus.ex_valid), 32'd0);

    // Advance a branch, then hold it with changed ID inputs
    stall = '0;
    apply_stimulus(1'b1, 8'h25, 3'd2, 32'h11, 32'h22, 5'd7, 1'b1, 32'h00221025, 32'h108, 1'b0, 1'b1);
    step();
    check_ex("adv2", 1, 8'h25, 3'd2, 32'h11, 32'h22, 5'd7, 1, 32'h00221025, 32'h108, 0);
    check_output("adv2.is_ds", 32'(is_ds), 32'd1);
    stall = 6'b001111;
    apply_stimulus(1'b1, 8'h99, 3'd5, 32'hAA, 32'hBB, 5'd9, 1'b0, 32'hDEADBEEF, 32'h200, 1'b1, 1'b0);
    step();
    step();
    check_ex("hold", 1, 8'h25, 3'd2, 32'h11, 32'h22, 5'd7, 1, 32'h00221025, 32'h108, 0);
    check_output("hold.is_ds", 32'(is_ds), 32'd1);
    check_output("hold.cnt", 32'(cnt), 32'd3);

    // Flush beats a full stall
    flush = 1'b1;
    step();
    check_ex("flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("flush.is_ds", 32'(is_ds), 32'd0);
    check_output("flush.cnt", 32'(cnt), 32'd3);

    // Branch then delay slot
    flush = 1'b0; stall = '0;
    apply_stimulus(1'b1, 8'h30, 3'd0, 32'd1, 32'd1, 5'd0, 1'b0, 32'h10210004, 32'h100, 1'b0, 1'b1);
    step();
    check_output("br.is_ds", 32'(is_ds), 32'd1);
    check_output("br.in_ds", 32'(bus.ex_in_delayslot), 32'd0);
    check_output("br.pc", bus.ex_pc, 32'h100);
    apply_stimulus(1'b1, 8'h21, 3'd1, 32'd2, 32'd3, 5'd4, 1'b1, 32'h00432021, 32'h104, 1'b1, 1'b0);
    step();
    check_output("ds.in_ds", 32'(bus.ex_in_delayslot), 32'd1);
    check_output("ds.pc", bus.ex_pc, 32'h104);
    check_output("ds.is_ds", 32'(is_ds), 32'd0);

    // Invalid slot advances as NOP but still updates delay-slot feedback
    apply_stimulus(1'b0, 8'h21, 3'd1, 32'd5, 32'd7, 5'd3, 1'b1, 32'h00A63821, 32'h10C, 1'b1, 1'b1);
    step();
    check_ex("inv", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("inv.is_ds", 32'(is_ds), 32'd1);

    // Bubble holds delay-slot feedback
    stall = 6'b000111;
    apply_stimulus(1'b1, 8'h21, 3'd1, 32'd5, 32'd7, 5'd3, 1'b1, 32'h00A63821, 32'h10C, 1'b0, 1'b0);
    step();
    check_output("bubds.is_ds", 32'(is_ds), 32'd1);
    check_output("bubds.cnt", 32'(cnt), 32'd4);

    // Only stall bits 2 and 3 matter: bit 2 clear means advance
    stall = 6'b111011;
    apply_stimulus(1'b1, 8'h42, 3'd3, 32'h5, 32'h6, 5'd8, 1'b1, 32'h12345678, 32'h110, 1'b0, 1'b0);
    step();
    check_ex("ign", 1, 8'h42, 3'd3, 32'h5, 32'h6, 5'd8, 1, 32'h12345678, 32'h110, 0);
    check_output("ign.cnt", 32'(cnt), 32'd4);
    check_output("ign.is_ds", 32'(is_ds), 32'd0);

    // Narrow counter saturates at 3
    stall = '0;
    stall_sat = 6'b000111;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_output($sformatf("sat%0d", i), 32'(cnt_sat), (i < 3) ? 32'(i) : 32'd3);
    end
    check_output("sat.cnt_main", 32'(cnt), 32'd4);

    // Reset in the middle of a hold
    stall_sat = '0;
    apply_stimulus(1'b1, 8'h21, 3'd1, 32'd9, 32'd8, 5'd2, 1'b1, 32'h01094021, 32'h120, 1'b0, 1'b1);
    step();
    stall = 6'b001111;
    step();
    check_output("mh.valid", 32'(bus.ex_valid), 32'd1);
    check_output("mh.pc", bus.ex_pc, 32'h120);
    check_output("mh.is_ds", 32'(is_ds), 32'd1);
    rst = 1'b1;
    step();
    check_ex("rsthold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rsthold.is_ds", 32'(is_ds), 32'd0);
    check_output("rsthold.cnt", 32'(cnt), 32'd0);
    check_output("rsthold.cnt_sat", 32'(cnt_sat), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
